// File: rtl/relu_maxpool2x2_pkg.sv
// Shared constants and FSM encoding for the ReLU + 2x2 max-pool + requantize stage.
package relu_maxpool2x2_pkg;

  localparam int DW_DEF    = 20;
  localparam int MAX_W_DEF = 256;
  localparam int SAT_MAX   = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/relu_maxpool2x2_pool_line_buf.sv
// Line buffer of even-row pair maxima, one entry per output column.
// Latency: write lands next cycle, read is combinational.
// Backpressure: none; the caller gates the write enable.
module pool_line_buf
  import relu_maxpool2x2_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = MAX_W_DEF / 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic signed [DW-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic signed [DW-1:0] rdata
);

  logic signed [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/relu_maxpool2x2.sv
// 2x2 stride-2 max-pool, ReLU and saturating requantize of a raster conv stream.
// Latency: pooled pixel valid one cycle after the odd-row/odd-column beat.
// Backpressure: s_ready drops while the single output register is stalled.
module relu_maxpool2x2
  import relu_maxpool2x2_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int MAX_W = MAX_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 done,
  input  logic [7:0]           in_width,
  input  logic [7:0]           in_height,
  input  logic [4:0]           shift,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [7:0]           m_data
);

  localparam int LB_DEPTH = MAX_W / 2;
  localparam int LB_AW    = $clog2(LB_DEPTH);
  localparam logic signed [DW-1:0] SAT_V = DW'(SAT_MAX);

  state_t               state;
  logic [7:0]           w_q, h_q, col, row;
  logic [4:0]           sh_q;
  logic signed [DW-1:0] pair_reg, lb_rdata, pm, pv;
  logic [LB_AW-1:0]     lb_addr;
  logic                 accept, last_col, last_row, lb_we, out_load;

  function automatic logic [7:0] requant(input logic signed [DW-1:0] v,
                                         input logic [4:0] sh);
    logic signed [DW-1:0] t;
    t = v >>> sh;
    if (v <= 0)          return 8'd0;
    else if (t > SAT_V)  return 8'(SAT_MAX);
    else                 return t[7:0];
  endfunction

  assign s_ready  = (state == ST_RUN) && !(m_valid && !m_ready);
  assign accept   = s_valid && s_ready;
  assign last_col = (col == w_q - 8'd1);
  assign last_row = (row == h_q - 8'd1);
  assign lb_addr  = LB_AW'(col >> 1);
  assign pm       = (s_data > pair_reg) ? s_data : pair_reg;
  assign pv       = (lb_rdata > pm) ? lb_rdata : pm;
  // Even rows park the horizontal max; odd rows combine it with their own.
  assign lb_we    = accept && col[0] && !row[0];
  assign out_load = accept && col[0] && row[0];

  pool_line_buf #(.DW(DW), .DEPTH(LB_DEPTH)) u_line_buf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (pm),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      w_q      <= '0;
      h_q      <= '0;
      sh_q     <= '0;
      col      <= '0;
      row      <= '0;
      pair_reg <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (out_load) begin
        m_valid <= 1'b1;
        m_data  <= requant(pv, sh_q);
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      if (accept && !col[0]) pair_reg <= s_data;

      case (state)
        ST_IDLE: begin
          if (start) begin
            w_q  <= in_width;
            h_q  <= in_height;
            sh_q <= shift;
            col  <= '0;
            row  <= '0;
            if (in_width == 8'd0 || in_height == 8'd0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (last_col) begin
              col <= '0;
              row <= row + 8'd1;
              if (last_row) state <= ST_FLUSH;
            end else begin
              col <= col + 8'd1;
            end
          end
        end
        ST_FLUSH: begin
          if (!m_valid || m_ready) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Directed and randomized frames checked against an arithmetic pooling model.
module tb_relu_maxpool2x2;

  localparam int DW = 20;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 done;
  logic [7:0]           in_width = '0;
  logic [7:0]           in_height = '0;
  logic [4:0]           shift = '0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic signed [DW-1:0] s_data = '0;
  logic                 m_valid;
  logic                 m_ready = 1'b1;
  logic [7:0]           m_data;

  always #5 clk = ~clk;

  relu_maxpool2x2 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .done      (done),
    .in_width  (in_width),
    .in_height (in_height),
    .shift     (shift),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data)
  );

  int checks = 0;
  int errors = 0;
  int beats[$];
  int expq[$];
  int got[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qref(input int v, input int sh);
    int t;
    if (v <= 0) return 0;
    t = v >> sh;
    return (t > 255) ? 255 : t;
  endfunction

  // Expected pooled pixels: max of each full 2x2 window, then requantized.
  task automatic build_model(input int w, input int h, input int sh);
    int m;
    expq.delete();
    for (int pr = 0; pr < h / 2; pr++)
      for (int pc = 0; pc < w / 2; pc++) begin
        m = beats[2*pr*w + 2*pc];
        if (beats[2*pr*w + 2*pc + 1] > m)     m = beats[2*pr*w + 2*pc + 1];
        if (beats[(2*pr+1)*w + 2*pc] > m)     m = beats[(2*pr+1)*w + 2*pc];
        if (beats[(2*pr+1)*w + 2*pc + 1] > m) m = beats[(2*pr+1)*w + 2*pc + 1];
        expq.push_back(qref(m, sh));
      end
  endtask

  // rmode: 0 = always ready, 1 = ready pattern 1-0-0-1, 2 = random valid/ready.
  task automatic run_frame(input string tag, input int w, input int h, input int sh,
                           input int rmode, input int restart_at);
    int idx = 0, cyc = 0, ndone = 0, done_cyc = -1, last_take = -1, last_acc = -1, e;
    logic stall_prev = 1'b0;
    logic [7:0] held = '0;
    bit finished = 0;
    build_model(w, h, sh);
    got.delete();
    @(negedge clk);
    start = 1'b1; in_width = 8'(w); in_height = 8'(h); shift = 5'(sh);
    while (!finished) begin
      @(negedge clk);
      start = (cyc == restart_at);
      if (cyc == restart_at) begin in_width = 8'd2; in_height = 8'd2; shift = 5'd7; end
      s_valid = (idx < w*h) && (rmode != 2 || $urandom_range(0, 3) != 0);
      if (idx < w*h) s_data = DW'(beats[idx]); else s_data = '0;
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (stall_prev) begin
        chk({tag, " hold_valid"}, m_valid, 1);
        chk({tag, " hold_data"}, m_data, held);
      end
      if (m_valid && !m_ready) chk({tag, " s_ready_stall"}, s_ready, 0);
      if (m_valid && m_ready) begin got.push_back(int'(m_data)); last_take = cyc; end
      if (s_valid && s_ready) begin idx++; last_acc = cyc; end
      if (done) begin ndone++; if (done_cyc < 0) done_cyc = cyc; end
      stall_prev = m_valid && !m_ready;
      held = m_data;
      cyc++;
      if ((done_cyc >= 0 && cyc > done_cyc + 3) || cyc > 5000) finished = 1;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    chk({tag, " out_count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      if (i < got.size()) chk({tag, $sformatf(" out%0d", i)}, got[i], expq[i]);
    chk({tag, " done_pulses"}, ndone, 1);
    chk({tag, " beats_consumed"}, idx, w*h);
    if (w*h > 0 && done_cyc >= 0) begin
      e = (last_take + 1 > last_acc + 2) ? last_take + 1 : last_acc + 2;
      chk({tag, " done_cycle"}, done_cyc, e);
    end
  endtask

  task automatic fill_ramp(input int n);
    beats.delete();
    for (int i = 0; i < n; i++) beats.push_back(i);
  endtask

  task automatic fill_random(input int n, input bit wide);
    beats.delete();
    for (int i = 0; i < n; i++)
      if (wide) beats.push_back(int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19));
      else      beats.push_back(int'($urandom_range(0, 4095)) - 1024);
  endtask

  initial begin
    int w, h, dn;
    repeat (2) @(negedge clk);
    #1;
    chk("reset s_ready", s_ready, 0);
    chk("reset m_valid", m_valid, 0);
    chk("reset m_data", m_data, 0);
    chk("reset done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    fill_ramp(16);
    run_frame("f4x4", 4, 4, 0, 0, -1);

    beats.delete();
    beats = '{-100, -3, 40, 2000, -1, -50, 8, 16};
    run_frame("f4x2_sat", 4, 2, 2, 0, -1);

    beats.delete();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++) beats.push_back((c == 4 || r == 2) ? 200 : 9);
    run_frame("f5x3_odd", 5, 3, 0, 0, -1);

    fill_ramp(16);
    run_frame("f4x4_stall", 4, 4, 0, 1, -1);

    beats.delete();
    run_frame("w0", 0, 3, 0, 0, -1);

    fill_ramp(16);
    run_frame("f4x4_restart", 4, 4, 0, 0, 3);

    // Abort a 6x6 frame partway through its second row.
    fill_random(36, 0);
    @(negedge clk);
    start = 1'b1; in_width = 8'd6; in_height = 8'd6; shift = 5'd0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      start = 1'b0;
      s_valid = 1'b1; s_data = DW'(beats[i]); m_ready = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("abort m_valid", m_valid, 0);
    chk("abort m_data", m_data, 0);
    chk("abort s_ready", s_ready, 0);
    chk("abort done", done, 0);
    rst = 1'b0;
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (done) dn++;
    end
    chk("abort no_done", dn, 0);

    fill_ramp(16);
    run_frame("f4x4_after_abort", 4, 4, 0, 0, -1);

    for (int k = 0; k < 6; k++) begin
      w = $urandom_range(1, 12);
      h = $urandom_range(1, 8);
      fill_random(w*h, k[0]);
      run_frame($sformatf("rand%0d", k), w, h, $urandom_range(0, 12), 2, -1);
    end

    fill_random(200*4, 0);
    run_frame("wide200", 200, 4, 3, 2, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
